// File: rtl/risc_pkg.sv
// Shared RISC core constants and the boot loader state encoding.
package risc_pkg;

   localparam int AWIDTH_DEF = 5;
   localparam int DWIDTH_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      CSUM,
      RUN,
      DONE,
      ERR
   } ldr_state_e;

endpackage

// File: rtl/risc_prog_loader.sv
// Boot-time loader: LEN, data bytes, CSUM stream into program memory,
// then releases the core on a good checksum and waits for its halt.
module risc_prog_loader
   import risc_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [DWIDTH-1:0] rx_data,
   output logic              rx_ready,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic              cpu_halt,
   output logic              cpu_run,
   output logic              busy,
   output logic              load_err
);

   localparam logic [DWIDTH:0] CAP = (DWIDTH+1)'(2**AWIDTH);

   ldr_state_e        state_q, state_d;
   logic [DWIDTH-1:0] len_q, len_d;
   logic [DWIDTH-1:0] csum_q, csum_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              run_q, run_d;
   logic              err_q, err_d;

   logic xfer;
   logic len_bad;
   logic last;

   // Gated by reset so the source never sees ready while held in reset
   assign rx_ready  = rst && (state_q != RUN);
   assign xfer      = rx_valid && rx_ready;
   assign len_bad   = ({1'b0, rx_data} == '0) || ({1'b0, rx_data} > CAP);
   assign last      = (DWIDTH+1)'(cnt_q) == ({1'b0, len_q} - (DWIDTH+1)'(1));
   assign busy      = (state_q == DATA) || (state_q == CSUM);
   assign mem_wr    = wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_run   = run_q;
   assign load_err  = err_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      csum_d  = csum_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = 1'b0;
      run_d   = run_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (xfer) begin
               len_d   = rx_data;
               cnt_d   = '0;
               csum_d  = '0;
               run_d   = 1'b0;
               err_d   = len_bad;
               state_d = len_bad ? ERR : DATA;
            end
         end
         DATA: begin
            if (xfer) begin
               wr_d    = 1'b1;
               addr_d  = cnt_q;
               wdata_d = rx_data;
               csum_d  = csum_q + rx_data;
               cnt_d   = cnt_q + 1'b1;
               if (last) state_d = CSUM;
            end
         end
         CSUM: begin
            if (xfer) begin
               if (rx_data == csum_q) begin
                  state_d = RUN;
                  run_d   = 1'b1;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
         RUN: begin
            // Core stays released after halt so its state can be inspected
            if (cpu_halt) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         csum_q  <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         csum_q  <= csum_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         run_q   <= run_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/risc_prog_loader.md
Name: risc_prog_loader

Overview:
- Boot-time program loader directly upstream of the RISC core's memory; runs before the CPU starts executing.
- Accepts a byte stream over a valid/ready handshake, writes it into program/data memory from address 0, then verifies a checksum.
- On success it releases the CPU (`cpu_run`) and watches `halt`. On failure it holds the CPU and flags an error.

Parameters:
- AWIDTH, 5, memory address width; capacity = 2**AWIDTH words
- DWIDTH, 8, memory word and stream byte width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rx_valid  input  1  stream byte valid
- rx_data  input  DWIDTH  stream byte
- rx_ready  output  1  loader can accept a byte
- mem_wr  output  1  memory write strobe, one cycle per word
- mem_addr  output  AWIDTH  memory write address
- mem_wdata  output  DWIDTH  memory write data
- cpu_halt  input  1  core halt flag
- cpu_run  output  1  1 = core released; integration gates core reset/enable with it
- busy  output  1  a load is in progress (LEN_WAIT excluded)
- load_err  output  1  last load failed (bad length or checksum)

Behaviour:
- Reset values (`rst` low, asynchronous):
  - State = IDLE.
  - `rx_ready`=0 during reset.
  - `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_run`=0, `busy`=0, `load_err`=0.
  - Word counter and checksum = 0.
- Transfer rule: a byte transfers on a rising edge where `rx_valid && rx_ready`. At most one byte per cycle.
- `rx_ready` is a decode of the registered state: 1 in IDLE, DATA, CSUM, DONE and ERR; 0 in RUN.
- Stream format: LEN byte L, then L data bytes, then one CSUM byte.
  - Valid L is 1..2**AWIDTH, compared at DWIDTH+1 bits.
  - CSUM = modulo-2**DWIDTH sum of the data bytes.
- IDLE:
  - On transfer, latch L and clear counter/checksum.
  - Set `load_err`=0 and `cpu_run`=0.
  - If L==0 or L>2**AWIDTH, go to ERR and set `load_err`=1; otherwise go to DATA.
- DATA, on each transfer:
  - Next edge registers `mem_addr`=counter, `mem_wdata`=`rx_data`, `mem_wr`=1. The write is visible to memory 1 cycle after the accepting edge.
  - `mem_wr` returns to 0 on the following edge unless another byte transfers.
  - checksum += `rx_data` (wraps); counter++.
  - When counter reaches L-1 on a transfer, go to CSUM.
  - Back-to-back bytes produce back-to-back writes.
  - Gaps (`rx_valid`=0) are legal and produce no writes.
- CSUM, on transfer:
  - If `rx_data`==checksum, go to RUN and set `cpu_run`=1 on the same edge.
  - Otherwise go to ERR and set `load_err`=1.
- RUN:
  - `cpu_run`=1, `rx_ready`=0.
  - When `cpu_halt`=1 is sampled, go to DONE; `cpu_run` stays 1 so the halted core state is preserved.
- DONE:
  - `rx_ready`=1.
  - A transfer is treated as a new LEN byte with exactly the IDLE behaviour, including dropping `cpu_run` to 0 on that edge.
- ERR:
  - `cpu_run`=0, `load_err` held at 1.
  - A transfer is a new LEN byte, handled as in IDLE; `load_err` clears only if that L is valid.
- `busy`=1 in DATA and CSUM only.
- Simultaneous events:
  - `cpu_halt` outside RUN is ignored.
  - `rx_valid` in RUN is not accepted; the byte is held by the source.
- Reset mid-load:
  - Everything returns to reset values immediately.
  - Memory contents already written are not cleared.
  - The next byte after reset deassertion is a LEN byte.
- Memory-write latency is 1 cycle; release latency from the accepting CSUM edge to `cpu_run`=1 is 0 cycles.

Decomposition:
- Shared package `risc_pkg`:
  - State enum {IDLE, DATA, CSUM, RUN, DONE, ERR}.
  - Default AWIDTH/DWIDTH constants, shared with the core top.
- No sub-module:
  - Counter and checksum accumulator are inline.
  - The existing phase/PC counter module is not reused because its reset polarity differs.

Test Plan:
- Basic load: reset, then stream L=3, 0x11,0x22,0x33, CSUM=0x66 back-to-back → `mem_wr` pulses at addr 0,1,2 with those data; `cpu_run` rises on the CSUM edge; `load_err`=0.
- Bad checksum: L=2, 0xF0,0x20, CSUM=0x11 (correct is 0x10, wrapped) → ERR; `load_err`=1; `cpu_run`=0; `rx_ready`=1.
- Illegal length: L=0, then separately L=33 → ERR immediately with no `mem_wr`. A following valid L=1, 0x05, CSUM=0x05 recovers and releases the CPU.
- Full capacity with gaps: L=32, data 0..31 with `rx_valid` toggling → 32 writes at addr 0..31; CSUM=0xF0 accepted; no write occurs on gap cycles.
- Run/halt/reload: in RUN hold `rx_valid`=1 → `rx_ready`=0 and no transfer. Assert `cpu_halt` → DONE with `cpu_run` still 1. Next LEN byte drops `cpu_run` on the accepting edge.
- Reset mid-load: assert `rst` low after 2 of 4 data bytes → all outputs 0 asynchronously. After release, L=1, 0xAA, CSUM=0xAA → write at addr 0 and `cpu_run`=1.
